// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package int_ctrl_pkg;

  localparam int IC_W      = 4;
  localparam int MAX_LINES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // One-hot vector with a single bit set at position idx.
  function automatic logic [MAX_LINES-1:0] onehot(input logic [IC_W-1:0] idx);
    return {{(MAX_LINES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc16.sv
// Fixed-priority encoder: index of the lowest set bit of a 16-bit request vector.
// Latency: purely combinational.
// Backpressure: none; vld is low when no bit is set (idx is then 0).
module prio_enc16
  import int_ctrl_pkg::*;
(
  input  logic [MAX_LINES-1:0] req,
  output logic [IC_W-1:0]      idx,
  output logic                 vld
);

  // Scan from the top down so the lowest set bit is the last to overwrite idx.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = MAX_LINES - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IC_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending lines, enable mask, lowest-index priority, non-nesting ACK/EOI handshake.
// Latency: a line edge sampled at edge k is pending after k; IRQ rises after k+1 when enabled and idle.
// Backpressure: IRQ/IC held until ACK; new requests are blocked until EOI. Build with INTC_LEVEL_EN for level-sensitive lines.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int              NUM_LINES  = 16,
  parameter logic [15:0]     RESET_MASK = 16'h0000
)(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_LINES-1:0] IRQ_IN,
  input  logic                 MASK_WE,
  input  logic [15:0]          MASK_DIN,
  input  logic                 ACK,
  input  logic                 EOI,
  output logic                 IRQ,
  output logic [3:0]           IC,
  output logic [15:0]          MASK_Q,
  output logic [15:0]          PENDING
);

  logic [MAX_LINES-1:0] irq_ext;
  logic [MAX_LINES-1:0] pend;
  logic [MAX_LINES-1:0] mask_q;
  logic [MAX_LINES-1:0] eligible;
  logic [IC_W-1:0]      win_idx;
  logic                 win_vld;
  state_t               state_q, state_nxt;
  logic [IC_W-1:0]      ic_q, ic_nxt;

  // Lines above NUM_LINES are tied inactive so they can never become pending.
  for (genvar g = 0; g < MAX_LINES; g++) begin : g_ext
    if (g < NUM_LINES) begin : g_on
      assign irq_ext[g] = IRQ_IN[g];
    end else begin : g_off
      assign irq_ext[g] = 1'b0;
    end
  end

`ifdef INTC_LEVEL_EN
  // Level mode: the raw lines are the pending view; nothing is latched or cleared.
  assign pend = irq_ext;
`else
  logic [MAX_LINES-1:0] prev_q;
  logic [MAX_LINES-1:0] pend_q;
  logic [MAX_LINES-1:0] edge_det;
  logic [MAX_LINES-1:0] clr;

  assign edge_det = irq_ext & ~prev_q;
  assign clr      = (state_q == ST_REQ && ACK) ? onehot(ic_q) : '0;
  assign pend     = pend_q;

  // Sample lines for edge detection and latch edges; a same-cycle edge beats the ACK clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= irq_ext;
      pend_q <= (pend_q & ~clr) | edge_det;
    end
  end
`endif

  // Software-writable enable mask; a write is visible to arbitration from the next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mask_q <= RESET_MASK;
    end else if (MASK_WE) begin
      mask_q <= MASK_DIN;
    end
  end

  assign eligible = pend & mask_q;

  prio_enc16 u_prio (
    .req (eligible),
    .idx (win_idx),
    .vld (win_vld)
  );

  // State register together with the frozen interrupt code.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ic_q    <= '0;
    end else begin
      state_q <= state_nxt;
      ic_q    <= ic_nxt;
    end
  end

  // Next-state: IC is captured only on the IDLE->REQ transition and held otherwise.
  always_comb begin
    state_nxt = state_q;
    ic_nxt    = ic_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_nxt = ST_REQ;
          ic_nxt    = win_idx;
        end
      end
      ST_REQ: begin
        if (ACK) begin
          state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (EOI) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs: IRQ only while waiting for ACK; IC always shows the last captured code.
  always_comb begin
    IRQ     = (state_q == ST_REQ);
    IC      = ic_q;
    MASK_Q  = mask_q;
    PENDING = pend;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios followed by randomized traffic.
// Latency: each tick samples outputs 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_int_ctrl;

  localparam logic [15:0] RMASK = 16'hA5A5;

  logic        CLK = 1'b0;
  logic        rst;
  logic [15:0] irq_in;
  logic        mask_we;
  logic [15:0] mask_din;
  logic        ack;
  logic        eoi;
  logic        irq;
  logic [3:0]  ic;
  logic [15:0] mask_q;
  logic [15:0] pending;

  int checks   = 0;
  int failures = 0;

  // Reference model: a set of pending lines, a mask, and a two-flag handshake phase.
  logic [15:0] m_pend;
  logic [15:0] m_mask;
  logic [15:0] m_last;
  bit          m_req;
  bit          m_svc;
  int          m_ic;

  int_ctrl #(.NUM_LINES(16), .RESET_MASK(RMASK)) dut (
    .CLK      (CLK),
    .RST      (rst),
    .IRQ_IN   (irq_in),
    .MASK_WE  (mask_we),
    .MASK_DIN (mask_din),
    .ACK      (ack),
    .EOI      (eoi),
    .IRQ      (irq),
    .IC       (ic),
    .MASK_Q   (mask_q),
    .PENDING  (pending)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_step();
    logic [15:0] elig;
    logic [15:0] rising;
    if (rst) begin
      m_pend = '0;
      m_mask = RMASK;
      m_last = '0;
      m_req  = 0;
      m_svc  = 0;
      m_ic   = 0;
    end else begin
      elig   = m_pend & m_mask;
      rising = irq_in & ~m_last;
      m_last = irq_in;
      if (m_req && ack) m_pend[m_ic] = 1'b0;
      m_pend = m_pend | rising;
      if (!m_req && !m_svc) begin
        if (elig != 16'h0) begin
          m_ic  = lowest(elig);
          m_req = 1;
        end
      end else if (m_req) begin
        if (ack) begin
          m_req = 0;
          m_svc = 1;
        end
      end else if (eoi) begin
        m_svc = 0;
      end
      if (mask_we) m_mask = mask_din;
    end
  endtask

  task automatic tick();
    logic [3:0] eic;
    @(posedge CLK);
    model_step();
    #1;
    eic = m_ic[3:0];
    chk("m_irq", {15'b0, irq}, {15'b0, m_req});
    chk("m_ic", {12'b0, ic}, {12'b0, eic});
    chk("m_pending", pending, m_pend);
    chk("m_mask", mask_q, m_mask);
  endtask

  task automatic pulse_line(input int n);
    irq_in    = '0;
    irq_in[n] = 1'b1;
    tick();
    irq_in = '0;
  endtask

  task automatic write_mask(input logic [15:0] v);
    mask_we  = 1'b1;
    mask_din = v;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic eoi_pulse();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_din = '0; ack = 1'b0; eoi = 1'b0;

    // Reset state
    tick();
    rst = 1'b0;
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    chk("rst_ic", {12'b0, ic}, 16'h0000);
    chk("rst_pending", pending, 16'h0000);
    chk("rst_mask", mask_q, RMASK);

    // Single line 5, two-edge latency, ACK clears, EOI returns to idle
    write_mask(16'h0020);
    pulse_line(5);
    chk("l5_pend", pending, 16'h0020);
    chk("l5_irq_early", {15'b0, irq}, 16'h0000);
    tick();
    chk("l5_irq", {15'b0, irq}, 16'h0001);
    chk("l5_ic", {12'b0, ic}, 16'h0005);
    ack_pulse();
    chk("l5_ack_pend", pending, 16'h0000);
    chk("l5_ack_irq", {15'b0, irq}, 16'h0000);
    eoi_pulse();
    tick();
    chk("l5_idle_irq", {15'b0, irq}, 16'h0000);

    // Simultaneous lines 3 and 9: priority, then the remaining one after EOI
    write_mask(16'hFFFF);
    irq_in = 16'h0208;
    tick();
    irq_in = '0;
    tick();
    chk("p39_ic_first", {12'b0, ic}, 16'h0003);
    chk("p39_irq_first", {15'b0, irq}, 16'h0001);
    ack_pulse();
    eoi_pulse();
    tick();
    chk("p39_ic_second", {12'b0, ic}, 16'h0009);
    chk("p39_irq_second", {15'b0, irq}, 16'h0001);
    ack_pulse();
    eoi_pulse();

    // Masked line stays pending and is requested once enabled
    write_mask(16'h0000);
    pulse_line(2);
    tick();
    tick();
    chk("mask_irq_off", {15'b0, irq}, 16'h0000);
    chk("mask_pend", pending, 16'h0004);
    write_mask(16'h0004);
    tick();
    chk("mask_irq_on", {15'b0, irq}, 16'h0001);
    chk("mask_ic", {12'b0, ic}, 16'h0002);
    ack_pulse();
    eoi_pulse();

    // New edge on the acknowledged line in the ACK cycle stays pending
    write_mask(16'hFFFF);
    pulse_line(7);
    tick();
    chk("l7_ic", {12'b0, ic}, 16'h0007);
    irq_in[7] = 1'b1;
    ack = 1'b1;
    tick();
    irq_in = '0;
    ack = 1'b0;
    chk("l7_pend_kept", {15'b0, pending[7]}, 16'h0001);
    chk("l7_svc_irq", {15'b0, irq}, 16'h0000);
    eoi_pulse();
    tick();
    chk("l7_re_irq", {15'b0, irq}, 16'h0001);
    chk("l7_re_ic", {12'b0, ic}, 16'h0007);
    ack_pulse();
    eoi_pulse();

    // Higher-priority edge during REQ does not change IC
    pulse_line(4);
    tick();
    chk("l4_ic", {12'b0, ic}, 16'h0004);
    pulse_line(1);
    tick();
    chk("l4_ic_frozen", {12'b0, ic}, 16'h0004);
    chk("l4_irq_held", {15'b0, irq}, 16'h0001);
    ack_pulse();
    eoi_pulse();
    tick();
    chk("l1_ic", {12'b0, ic}, 16'h0001);
    ack_pulse();
    eoi_pulse();

    // ACK and EOI together in REQ: ACK taken, EOI ignored
    pulse_line(11);
    tick();
    ack = 1'b1;
    eoi = 1'b1;
    tick();
    ack = 1'b0;
    eoi = 1'b0;
    tick();
    chk("ackeoi_still_svc", {15'b0, irq}, 16'h0000);
    pulse_line(12);
    tick();
    chk("ackeoi_blocked", {15'b0, irq}, 16'h0000);
    eoi_pulse();
    tick();
    chk("ackeoi_next_ic", {12'b0, ic}, 16'h000C);
    ack_pulse();
    eoi_pulse();

    // Reset during SERVICE abandons it
    pulse_line(6);
    tick();
    pulse_line(10);
    ack_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsvc_irq", {15'b0, irq}, 16'h0000);
    chk("rsvc_ic", {12'b0, ic}, 16'h0000);
    chk("rsvc_pending", pending, 16'h0000);
    chk("rsvc_mask", mask_q, RMASK);
    eoi_pulse();
    chk("rsvc_eoi_irq", {15'b0, irq}, 16'h0000);

    // Line already high when reset deasserts counts as an edge
    irq_in = 16'h0001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rhi_pend", pending, 16'h0001);
    tick();
    chk("rhi_irq", {15'b0, irq}, 16'h0001);
    chk("rhi_ic", {12'b0, ic}, 16'h0000);
    irq_in = '0;
    ack_pulse();
    eoi_pulse();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(299) == 0);
      irq_in   = 16'($urandom & $urandom & $urandom);
      ack      = ($urandom_range(3) == 0);
      eoi      = ($urandom_range(3) == 0);
      mask_we  = ($urandom_range(11) == 0);
      mask_din = 16'($urandom);
      tick();
    end
    rst = 1'b0; irq_in = '0; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller directly upstream of the CPU; drives its IRQ and IC[3:0] inputs.
- Edge-detects up to 16 peripheral lines, latches them as pending, applies a software-writable enable mask, and selects the highest-priority request.
- Holds IRQ/IC stable until the CPU acknowledges, then blocks further requests until end-of-interrupt (no nesting).

Parameters:
- NUM_LINES, 16, number of interrupt inputs (1..16); bits at or above NUM_LINES are tied inactive.
- RESET_MASK, 16'h0000, mask value loaded on reset (1 = line enabled).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- IRQ_IN  input  NUM_LINES  raw peripheral request lines, synchronous to CLK.
- MASK_WE  input  1  write strobe for the mask register.
- MASK_DIN  input  16  new mask value.
- ACK  input  1  CPU acknowledges the current request; one-cycle pulse.
- EOI  input  1  CPU end-of-interrupt; one-cycle pulse.
- IRQ  output  1  interrupt request to CPU.
- IC  output  4  interrupt code (line index) to CPU; valid while IRQ=1.
- MASK_Q  output  16  current mask register.
- PENDING  output  16  pending register (unmasked view).

Behaviour:
- Reset (RST=1 at a rising edge): IRQ=0, IC=0, PENDING=0, MASK_Q=RESET_MASK, prev-sample register=0, state=IDLE. Reset mid-request or mid-service abandons it; no ACK/EOI needed afterwards.
- Edge detect: edge[i] = IRQ_IN[i] & ~prev[i]; prev <= IRQ_IN every cycle. A line already high when reset deasserts counts as an edge on the first post-reset cycle.
- Pending update, per bit: pending <= (pending & ~clr) | edge.
  - clr is one-hot on IC when ACK is accepted.
  - Set wins over clear in the same cycle: a new edge stays pending.
- Mask: MASK_WE=1 loads MASK_DIN at that edge; the new value is used from the next cycle. Masked pending bits stay pending and are requested once unmasked.
- Eligible = pending & mask. Priority: lowest index wins (line 0 highest).
- FSM:
  - IDLE: IRQ=0. If eligible≠0, latch IC = winning index, go to REQ.
  - REQ: IRQ=1, IC frozen. Masking the line or new higher-priority edges do not change IC or withdraw IRQ. On ACK: clear pending[IC], go to SERVICE.
  - SERVICE: IRQ=0, IC holds its last value. On EOI, go to IDLE.
  - ACK outside REQ and EOI outside SERVICE are ignored.
- Latency:
  - IRQ_IN high at rising edge k sets pending at k.
  - If enabled and in IDLE, IRQ=1 after edge k+1 (two edges from first sample).
  - After EOI at edge m, the next request can assert IRQ after edge m+1.
  - ACK and EOI in the same cycle while in REQ: ACK is taken and EOI is ignored.

Optional Feature:
- Macro INTC_LEVEL_EN.
- Defined: level-sensitive mode. Pending = IRQ_IN (combinational view, no latch); edge detector and clr logic are removed. ACK only advances the FSM. A line must stay high until ACK, or IRQ still holds its frozen IC through REQ.
- Undefined: edge-latched behaviour as above.

Decomposition:
- Package int_ctrl_pkg:
  - state encodings ST_IDLE=2'd0, ST_REQ=2'd1, ST_SERVICE=2'd2.
  - IC_W=4 and MAX_LINES=16.
- One sub-module, prio_enc16: 16-bit input to 4-bit lowest-set index plus a valid flag. It is combinational and instantiated once.

Test Plan:
- Reset, then a pulse on IRQ_IN[5] with MASK=16'h0020 -> IRQ=1, IC=5 two edges after the pulse; ACK -> PENDING[5]=0, IRQ=0; EOI -> IDLE.
- Edges on lines 3 and 9 in the same cycle, MASK=16'hFFFF -> IC=3 first; after ACK+EOI, IC=9 two edges later.
- Edge on line 2 with MASK=0 -> no IRQ, PENDING=16'h0004; write MASK=16'h0004 -> IRQ=1, IC=2 within 2 cycles.
- In REQ with IC=7, new edge on line 7 in the ACK cycle -> PENDING[7] stays 1; after EOI, IRQ reasserts with IC=7.
- In REQ with IC=4, edge on line 1 arrives -> IC stays 4 until ACK; after EOI, IC=1.
- RST asserted during SERVICE -> next cycle IRQ=0, IC=0, PENDING=0, MASK_Q=RESET_MASK; a subsequent EOI is ignored.
